// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory responder: FSM encodings,
// data width and the NOP word returned for out-of-range fetches.
package imem_pkg;

    localparam int IMEM_XLEN = 32;

    localparam logic [IMEM_XLEN-1:0] IMEM_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IMEM_IDLE = 2'd0,
        IMEM_WAIT = 2'd1,
        IMEM_RESP = 2'd2
    } imem_state_e;

endpackage : imem_pkg

// File: rtl/imem_responder_if.sv
// Fetch request/response handshake plus the program-load write port.
// master = fetch stage / loader side, slave = memory responder side.
interface imem_responder_if;
    import imem_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic [IMEM_XLEN-1:0] req_addr;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [IMEM_XLEN-1:0] resp_instruction;
    logic [IMEM_XLEN-1:0] resp_addr;
    logic                 resp_error;
    logic                 prog_we;
    logic [IMEM_XLEN-1:0] prog_addr;
    logic [IMEM_XLEN-1:0] prog_data;

    modport master (
        output req_valid, req_addr, resp_ready, prog_we, prog_addr, prog_data,
        input  req_ready, resp_valid, resp_instruction, resp_addr, resp_error
    );

    modport slave (
        input  req_valid, req_addr, resp_ready, prog_we, prog_addr, prog_data,
        output req_ready, resp_valid, resp_instruction, resp_addr, resp_error
    );

endinterface : imem_responder_if

// File: rtl/imem_array.sv
// Word storage with a synchronous write port and a read port that captures
// the addressed word into a hold register on the accept edge.
module imem_array
    import imem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] wr_idx,
    input  logic [IMEM_XLEN-1:0]           wr_data,
    input  logic                           rd_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] rd_idx,
    output logic [IMEM_XLEN-1:0]           rd_data
);

    logic [IMEM_XLEN-1:0] mem [DEPTH_WORDS];
    logic [IMEM_XLEN-1:0] rd_data_q;
    logic [IMEM_XLEN-1:0] rd_data_d;

    // Contents survive reset so a loaded program is kept across it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Same-cycle write/read to one word sees the old contents here.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_idx];
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= {IMEM_XLEN{1'b0}};
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule : imem_array

// File: rtl/imem_responder.sv
// Instruction-memory responder: one outstanding fetch, answered LATENCY cycles
// after acceptance and held until taken. Bounds checking: `IMEM_BOUNDS_CHECK_EN.
module imem_responder
    import imem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic            clk,
    input  logic            reset,
    imem_responder_if.slave bus
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    imem_state_e          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IMEM_XLEN-1:0] hold_addr_q, hold_addr_d;
    logic                 hold_err_q, hold_err_d;
    logic                 resp_valid_q, resp_valid_d;
    logic [IMEM_XLEN-1:0] resp_instr_q, resp_instr_d;
    logic [IMEM_XLEN-1:0] resp_addr_q, resp_addr_d;
    logic                 resp_err_q, resp_err_d;

    logic                 req_ready_s;
    logic                 accept_s;
    logic                 wait_done_s;
    logic                 req_hi_s, prog_hi_s;
    logic                 req_oob_s, prog_oob_s;
    logic                 wr_en_s;
    logic [IMEM_XLEN-1:0] rd_data_s;
    logic                 unused_s;

    assign req_ready_s = (state_q == IMEM_IDLE) & ~reset;
    assign accept_s    = bus.req_valid & req_ready_s;
    assign wait_done_s = (state_q == IMEM_WAIT) && (cnt_q == {CW{1'b0}});

    assign req_hi_s  = |bus.req_addr[IMEM_XLEN-1:AW+2];
    assign prog_hi_s = |bus.prog_addr[IMEM_XLEN-1:AW+2];

`ifdef IMEM_BOUNDS_CHECK_EN
    assign req_oob_s  = req_hi_s;
    assign prog_oob_s = prog_hi_s;
    assign unused_s   = ^{bus.req_addr[1:0], bus.prog_addr[1:0]};
`else
    // Without bounds checking the upper address bits are simply dropped (wrap).
    assign req_oob_s  = 1'b0;
    assign prog_oob_s = 1'b0;
    assign unused_s   = ^{bus.req_addr[1:0], bus.prog_addr[1:0], req_hi_s, prog_hi_s};
`endif

    assign wr_en_s = bus.prog_we & ~prog_oob_s;

    imem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (wr_en_s),
        .wr_idx (bus.prog_addr[AW+1:2]),
        .wr_data(bus.prog_data),
        .rd_en  (accept_s),
        .rd_idx (bus.req_addr[AW+1:2]),
        .rd_data(rd_data_s)
    );

    // State, counter and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IMEM_IDLE;
            cnt_q        <= {CW{1'b0}};
            hold_addr_q  <= {IMEM_XLEN{1'b0}};
            hold_err_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_instr_q <= {IMEM_XLEN{1'b0}};
            resp_addr_q  <= {IMEM_XLEN{1'b0}};
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hold_addr_q  <= hold_addr_d;
            hold_err_q   <= hold_err_d;
            resp_valid_q <= resp_valid_d;
            resp_instr_q <= resp_instr_d;
            resp_addr_q  <= resp_addr_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Counter holds the remaining WAIT cycles; zero means the next edge enters RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IMEM_IDLE: begin
                if (accept_s) begin
                    state_d = IMEM_WAIT;
                    cnt_d   = CW'(LATENCY - 1);
                end else begin
                    state_d = IMEM_IDLE;
                end
            end
            IMEM_WAIT: begin
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = IMEM_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            IMEM_RESP: begin
                if (bus.resp_ready) begin
                    state_d = IMEM_IDLE;
                end else begin
                    state_d = IMEM_RESP;
                end
            end
            default: begin
                state_d = IMEM_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // Response outputs only load on the edge entering RESP, so later writes cannot disturb them.
    always_comb begin
        hold_addr_d  = hold_addr_q;
        hold_err_d   = hold_err_q;
        resp_valid_d = resp_valid_q;
        resp_instr_d = resp_instr_q;
        resp_addr_d  = resp_addr_q;
        resp_err_d   = resp_err_q;
        if (accept_s) begin
            hold_addr_d = bus.req_addr;
            hold_err_d  = req_oob_s;
        end else begin
            hold_addr_d = hold_addr_q;
        end
        if (wait_done_s) begin
            resp_valid_d = 1'b1;
            resp_instr_d = hold_err_q ? IMEM_NOP : rd_data_s;
            resp_addr_d  = hold_addr_q;
            resp_err_d   = hold_err_q;
        end else if ((state_q == IMEM_RESP) && bus.resp_ready) begin
            resp_valid_d = 1'b0;
        end else begin
            resp_valid_d = resp_valid_q;
        end
    end

    assign bus.req_ready        = req_ready_s;
    assign bus.resp_valid       = resp_valid_q;
    assign bus.resp_instruction = resp_instr_q;
    assign bus.resp_addr        = resp_addr_q;
    assign bus.resp_error       = resp_err_q;

endmodule : imem_responder
